// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and helpers for the hazard tracker.
//   DEF_REG_ADDR_W : default register-address width (sets stage_entry_t.dst width)
//   stage_entry_t  : {valid, wb_en, mem_r_en, dst} for one pipeline stage
//   BUBBLE         : empty stage entry
//   src_match      : does a used source register hit a writing stage entry
package hazard_pkg;
  localparam int DEF_REG_ADDR_W = 4;
  typedef struct packed {
    logic                      valid;
    logic                      wb_en;
    logic                      mem_r_en;
    logic [DEF_REG_ADDR_W-1:0] dst;
  } stage_entry_t;
  localparam stage_entry_t BUBBLE = '0;
  function automatic logic src_match(stage_entry_t s, logic use_src, logic [DEF_REG_ADDR_W-1:0] src);
    return s.valid & s.wb_en & use_src & (src == s.dst);
  endfunction
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one pipeline stage entry with async clear, hold and bubble insert.
//   clk, rst_n : clock, asynchronous active-low clear to BUBBLE
//   hold       : keep current entry (pipeline freeze), wins over bubble
//   bubble     : load BUBBLE instead of d
//   d / q      : next / current stage entry
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         bubble,
  input  stage_entry_t d,
  output stage_entry_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= BUBBLE;
    else if (!hold) q <= bubble ? BUBBLE : d;
endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks EXE/MEM/WB destination tags and raises the ID-stage hazard stall.
//   Inputs : clk, rst_n (async active-low), freeze, flush, forward_en,
//            id_valid, id_src1, id_src2, id_use_src1, id_two_src, id_wb_en, id_mem_r_en, id_dst
//   Outputs: hazard_stall (combinational), mem_wb_en/mem_dst, wb_wb_en/wb_dst (registered)
//   Option : define HAZARD_STATS_EN to add saturating stall_cnt and load_use_cnt outputs.
//   REG_ADDR_W must equal hazard_pkg::DEF_REG_ADDR_W, which sizes the stage entries.
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  forward_en,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_two_src,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic [REG_ADDR_W-1:0] id_dst,
  output logic                  hazard_stall,
  output logic                  mem_wb_en,
  output logic [REG_ADDR_W-1:0] mem_dst,
  output logic                  wb_wb_en,
  output logic [REG_ADDR_W-1:0] wb_dst
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0]    stall_cnt
  , output logic [CNT_W-1:0]    load_use_cnt
`endif
);
  stage_entry_t id_entry, exe_q, mem_q, wb_q;
  logic exe_hit, mem_hit, load_use;
  assign id_entry = '{valid: 1'b1, wb_en: id_wb_en, mem_r_en: id_mem_r_en, dst: id_dst};
  assign exe_hit = src_match(exe_q, id_use_src1, id_src1) | src_match(exe_q, id_two_src, id_src2);
  assign mem_hit = src_match(mem_q, id_use_src1, id_src1) | src_match(mem_q, id_two_src, id_src2);
  assign load_use = id_valid & exe_hit & exe_q.mem_r_en;
  // WB never stalls: the register file writes on the falling edge, ahead of the ID read
  assign hazard_stall = forward_en ? load_use : id_valid & (exe_hit | mem_hit);
  hazard_stage_reg u_exe (
    .clk(clk), .rst_n(rst_n), .hold(freeze),
    .bubble(hazard_stall | flush | !id_valid), .d(id_entry), .q(exe_q)
  );
  hazard_stage_reg u_mem (
    .clk(clk), .rst_n(rst_n), .hold(freeze), .bubble(1'b0), .d(exe_q), .q(mem_q)
  );
  hazard_stage_reg u_wb (
    .clk(clk), .rst_n(rst_n), .hold(freeze), .bubble(1'b0), .d(mem_q), .q(wb_q)
  );
  assign mem_wb_en = mem_q.valid & mem_q.wb_en;
  assign mem_dst   = mem_q.dst;
  assign wb_wb_en  = wb_q.valid & wb_q.wb_en;
  assign wb_dst    = wb_q.dst;
`ifdef HAZARD_STATS_EN
  // load_use implies hazard_stall in both forwarding modes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt    <= '0;
      load_use_cnt <= '0;
    end else if (!freeze) begin
      if (hazard_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (load_use && load_use_cnt != '1) load_use_cnt <= load_use_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: table-driven directed check of hazard_tracker plus corner-case sequences.
module tb_hazard_tracker;
  logic clk = 1'b0;
  logic rst_n, freeze, flush, forward_en, id_valid, id_use_src1, id_two_src, id_wb_en, id_mem_r_en;
  logic [3:0] id_src1, id_src2, id_dst, mem_dst, wb_dst;
  logic hazard_stall, mem_wb_en, wb_wb_en;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, load_use_cnt;
`endif
  int n_cmp = 0;
  int n_err = 0;

  hazard_tracker dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .forward_en(forward_en),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dst(id_dst),
    .hazard_stall(hazard_stall), .mem_wb_en(mem_wb_en), .mem_dst(mem_dst),
    .wb_wb_en(wb_wb_en), .wb_dst(wb_dst)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .load_use_cnt(load_use_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic frz, fl, fe, v, u1, two, wb, mr;
    logic [3:0] s1, s2, dst;
    logic e_st, e_mwb, e_wwb;
    logic [3:0] e_md, e_wd;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t vx(logic frz, logic fl, logic fe, logic v, logic u1, logic two,
                              logic wb, logic mr, logic [3:0] s1, logic [3:0] s2, logic [3:0] dst,
                              logic st, logic mwb, logic [3:0] md, logic wwb, logic [3:0] wd);
    vec_t r;
    r.frz = frz; r.fl = fl; r.fe = fe; r.v = v; r.u1 = u1; r.two = two; r.wb = wb; r.mr = mr;
    r.s1 = s1; r.s2 = s2; r.dst = dst;
    r.e_st = st; r.e_mwb = mwb; r.e_md = md; r.e_wwb = wwb; r.e_wd = wd;
    return r;
  endfunction

  function automatic vec_t idle(logic mwb, logic [3:0] md, logic wwb, logic [3:0] wd);
    return vx(0,0,1,0,0,0,0,0,0,0,0, 0,mwb,md,wwb,wd);
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    freeze = v.frz; flush = v.fl; forward_en = v.fe; id_valid = v.v;
    id_use_src1 = v.u1; id_two_src = v.two; id_wb_en = v.wb; id_mem_r_en = v.mr;
    id_src1 = v.s1; id_src2 = v.s2; id_dst = v.dst;
  endtask

  task automatic check_outs(string tag, logic st, logic mwb, logic [3:0] md, logic wwb, logic [3:0] wd);
    chk({tag, " hazard_stall"}, 16'(hazard_stall), 16'(st));
    chk({tag, " mem_wb_en"}, 16'(mem_wb_en), 16'(mwb));
    chk({tag, " mem_dst"}, 16'(mem_dst), 16'(md));
    chk({tag, " wb_wb_en"}, 16'(wb_wb_en), 16'(wwb));
    chk({tag, " wb_dst"}, 16'(wb_dst), 16'(wd));
  endtask

  initial begin
    // reset, then idle
    repeat (3) vq.push_back(idle(0,0,0,0));
    // load-use with forwarding: one bubble
    vq.push_back(vx(0,0,1,1,0,0,1,1,0,0,3, 0,0,0,0,0));
    vq.push_back(vx(0,0,1,1,1,0,1,0,3,0,7, 1,0,0,0,0));
    vq.push_back(vx(0,0,1,1,1,0,1,0,3,0,7, 0,1,3,0,0));
    vq.push_back(idle(0,0,1,3));
    vq.push_back(idle(1,7,0,0));
    vq.push_back(vx(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,1,7));
    // no forwarding: RAW on src2 stalls two cycles
    vq.push_back(vx(0,0,0,1,0,0,1,0,0,0,5, 0,0,0,0,0));
    vq.push_back(vx(0,0,0,1,0,1,1,0,0,5,6, 1,0,0,0,0));
    vq.push_back(vx(0,0,0,1,0,1,1,0,0,5,6, 1,1,5,0,0));
    vq.push_back(vx(0,0,0,1,0,1,1,0,0,5,6, 0,0,0,1,5));
    vq.push_back(idle(0,0,0,0));
    vq.push_back(idle(1,6,0,0));
    vq.push_back(idle(0,0,1,6));
    // forwarding, ALU dependency: no stall
    vq.push_back(vx(0,0,1,1,0,0,1,0,0,0,5, 0,0,0,0,0));
    vq.push_back(vx(0,0,1,1,1,0,1,0,5,0,9, 0,0,0,0,0));
    vq.push_back(idle(1,5,0,0));
    vq.push_back(idle(1,9,1,5));
    vq.push_back(idle(0,0,1,9));
    // non-writing producer, invalid consumer, register 0 via src2
    vq.push_back(vx(0,0,1,1,0,0,0,1,0,0,0, 0,0,0,0,0));
    vq.push_back(vx(0,0,1,1,1,0,1,0,0,0,1, 0,0,0,0,0));
    vq.push_back(vx(0,0,0,0,1,0,0,0,1,0,0, 0,0,0,0,0));
    vq.push_back(idle(1,1,0,0));
    vq.push_back(vx(0,0,1,1,0,0,1,1,0,0,0, 0,0,0,1,1));
    vq.push_back(vx(0,0,1,1,0,1,1,0,0,0,1, 1,0,0,0,0));
    vq.push_back(idle(1,0,0,0));
    vq.push_back(idle(0,0,1,0));
    // freeze holds all entries and the stall
    vq.push_back(vx(0,0,1,1,0,0,1,0,0,0,12, 0,0,0,0,0));
    vq.push_back(vx(0,0,1,1,0,0,1,1,0,0,2, 0,0,0,0,0));
    repeat (3) vq.push_back(vx(1,0,1,1,1,0,1,0,2,0,8, 1,1,12,0,0));
    vq.push_back(vx(0,0,1,1,1,0,1,0,2,0,8, 1,1,12,0,0));
    vq.push_back(vx(0,0,1,1,1,0,1,0,2,0,8, 0,1,2,1,12));
    vq.push_back(idle(0,0,1,2));
    vq.push_back(idle(1,8,0,0));
    vq.push_back(idle(0,0,1,8));
    // flush with stall, then unused-src1 match
    vq.push_back(vx(0,0,1,1,0,0,1,1,0,0,4, 0,0,0,0,0));
    vq.push_back(vx(0,1,1,1,1,0,1,0,4,0,10, 1,0,0,0,0));
    vq.push_back(vx(0,0,1,1,0,0,1,1,0,0,4, 0,1,4,0,0));
    vq.push_back(vx(0,0,1,1,0,0,1,0,4,0,11, 0,0,0,1,4));
    vq.push_back(idle(1,4,0,0));
    vq.push_back(idle(1,11,1,4));
    vq.push_back(idle(0,0,1,11));
    vq.push_back(idle(0,0,0,0));

    rst_n = 1'b0;
    drive(idle(0,0,0,0));
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    chk("reset stall_cnt", stall_cnt, 16'd0);
    chk("reset load_use_cnt", load_use_cnt, 16'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i]);
      #1;
      check_outs($sformatf("vec%0d", i), vq[i].e_st, vq[i].e_mwb, vq[i].e_md, vq[i].e_wwb, vq[i].e_wd);
      @(negedge clk);
    end

`ifdef HAZARD_STATS_EN
    chk("stall_cnt", stall_cnt, 16'd6);
    chk("load_use_cnt", load_use_cnt, 16'd4);
`endif

    // forward_en toggles combinationally, then async reset mid-cycle
    drive(vx(0,0,1,1,0,0,1,0,0,0,5, 0,0,0,0,0));
    @(negedge clk);
    drive(vx(0,0,1,1,0,0,1,0,0,0,6, 0,0,0,0,0));
    @(negedge clk);
    drive(vx(0,0,1,1,1,0,1,0,6,0,7, 0,0,0,0,0));
    #1;
    check_outs("toggle fe1", 0, 1, 5, 0, 0);
    forward_en = 1'b0;
    #1;
    chk("toggle fe0 hazard_stall", 16'(hazard_stall), 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("async reset", 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    chk("async reset stall_cnt", stall_cnt, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle(0,0,0,0));
    @(negedge clk);
    #1;
    check_outs("post reset", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Tracks the destination tags of in-flight instructions through the EXE, MEM and WB stages.
- Drives the MEM/WB destination and write-back-enable signals that the forwarding logic consumes.
- Raises the ID-stage stall for load-use hazards, and for all RAW hazards when forwarding is disabled.
- Sits beside the ID/EXE/MEM/WB pipeline registers and obeys the same freeze and flush controls.

Parameters:
REG_ADDR_W, 4, register-address width
CNT_W, 16, width of statistics counters (HAZARD_STATS_EN only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
freeze  in  1  global pipeline hold (memory wait); all stages hold
flush  in  1  branch taken; instruction leaving ID becomes a bubble
forward_en  in  1  forwarding enabled
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_ADDR_W  first source register
id_src2  in  REG_ADDR_W  second source register
id_use_src1  in  1  src1 is actually read
id_two_src  in  1  src2 is actually read
id_wb_en  in  1  ID instruction writes a register
id_mem_r_en  in  1  ID instruction is a load
id_dst  in  REG_ADDR_W  ID destination
hazard_stall  out  1  stall IF/ID; insert bubble into EXE
mem_wb_en  out  1  MEM-stage write enable (to forwarding)
mem_dst  out  REG_ADDR_W  MEM-stage destination
wb_wb_en  out  1  WB-stage write enable (to forwarding)
wb_dst  out  REG_ADDR_W  WB-stage destination

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset:
  - All three stage entries are cleared to BUBBLE (valid=0, wb_en=0, mem_r_en=0, dst=0).
  - Every output is 0, including hazard_stall, since it is derived from invalid entries.
  - Reset asserted mid-operation clears the entries immediately, without waiting for a clock edge.
- Stage entries: each of EXE, MEM and WB holds {valid, wb_en, mem_r_en, dst}.
- Per rising edge when freeze=0:
  - EXE <= BUBBLE if (hazard_stall | flush | !id_valid); otherwise EXE <= {1, id_wb_en, id_mem_r_en, id_dst}.
  - MEM <= EXE.
  - WB <= MEM.
- freeze=1: all entries hold. freeze has priority over flush and hazard_stall.
- Outputs:
  - mem_wb_en = MEM.valid & MEM.wb_en; mem_dst = MEM.dst.
  - wb_wb_en and wb_dst follow the same rule from WB.
  - These are registered, so there is no combinational path from ID inputs.
- Source match definitions:
  - m1(S) = S.valid & S.wb_en & id_use_src1 & (id_src1 == S.dst)
  - m2(S) = the same using id_two_src and id_src2
  - m(S) = m1(S) | m2(S)
- hazard_stall (combinational, qualified by id_valid):
  - forward_en=1: stall = m(EXE) & EXE.mem_r_en (load-use only). The result costs exactly one bubble, after which the load has moved to MEM and is forwarded.
  - forward_en=0: stall = m(EXE) | m(MEM).
  - The WB stage never causes a stall: the register file is write-first, i.e. it writes on the falling edge.
- Boundary conditions:
  - A match against a bubble or a non-writing instruction never stalls.
  - Register 0 is not special; all 16 registers compare.
  - forward_en may toggle at any time; stall follows it combinationally.
  - stall and flush together: flush wins, bubble inserted, ID discarded upstream.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, two extra outputs are present:
  - stall_cnt[CNT_W]: increments each cycle hazard_stall=1 and freeze=0.
  - load_use_cnt[CNT_W]: increments when that stall is a load-use stall.
- Both counters saturate at all-ones, reset to 0 and hold during freeze.
- When undefined, the ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_ADDR_W default
  - stage_entry_t typedef {valid, wb_en, mem_r_en, dst}
  - BUBBLE constant
- One natural sub-module, hazard_stage_reg: a single stage_entry_t register with async clear, hold (freeze) and bubble-insert inputs. It is instantiated three times.

Test Plan:
1. Reset, then idle with id_valid=0 -> all outputs 0; after 3 clocks entries are still bubbles.
2. forward_en=1: LDR dst=3, then ADD src1=3 -> hazard_stall=1 for exactly 1 cycle; two cycles later mem_wb_en=1, mem_dst=3, then wb_dst=3.
3. forward_en=0: ADD dst=5, then SUB src2=5 with two_src=1 -> stall for 2 cycles; released once dst=5 reaches WB.
4. forward_en=1: ADD dst=5, then SUB src1=5 -> no stall; next edge mem_dst=5, mem_wb_en=1.
5. freeze=1 for 3 cycles with LDR in EXE and dependent instruction in ID -> entries frozen, stall held at 1, counters frozen; after release the stall lasts 1 more cycle.
6. flush=1 with stall=1, then a match on id_use_src1=0 -> EXE becomes a bubble; with id_use_src1=0 the src1 match is ignored, no stall.
